// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: default widths and FSM state encoding.
package pc_pkg;

  localparam int unsigned AddrWDefault = 6;
  localparam int unsigned CntWDefault  = 8;

  // Encodings are visible on the debug state port, so values are fixed.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StHalt  = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_mux2.sv
// Plain 2:1 mux used for next-PC selection (6 bits wide by default).
module pc_sequencer_mux2 #(
  parameter int unsigned W = 6
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         s,
  output logic [W-1:0] y
);

  // s=1 selects d1, otherwise d0.
  always_comb begin
    y = s ? d1 : d0;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/FETCH/EXEC/HALT FSM with a one-deep jump request slot,
// wrap detection and a saturating retired-step counter.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned CNT_W  = CntWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              resume,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              jump_ack,
  output logic              jump_busy,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              sel,
  output logic              wrap,
  output logic [CNT_W-1:0]  step_cnt,
  output logic [1:0]        state
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_exec;
  logic              sel_int;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_next;

  assign in_exec = (state_q == StExec);
  assign sel_int = in_exec & pend_q;
  assign pc_inc  = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  pc_sequencer_mux2 #(
    .W (ADDR_W)
  ) u_next_pc_mux (
    .d0 (pc_inc),
    .d1 (tgt_q),
    .s  (sel_int),
    .y  (pc_next)
  );

  // Next-state logic for the FSM, PC, jump slot and step counter.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = StExec;
      StExec: begin
        pc_d    = pc_next;
        state_d = halt ? StHalt : StFetch;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      StHalt:  if (resume) state_d = StFetch;
      default: state_d = StIdle;
    endcase

    // A consuming EXEC clears the slot; a new request is only taken into an empty slot,
    // so a request in the consuming cycle is dropped.
    if (sel_int) begin
      pend_d = 1'b0;
    end else if (!pend_q && jump_req) begin
      pend_d = 1'b1;
      tgt_d  = jump_addr;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for as long as reset is held.
  always_comb begin
    jump_ack  = ~rst & sel_int;
    sel       = ~rst & sel_int;
    wrap      = ~rst & in_exec & ~pend_q & (&pc_q);
    jump_busy = ~rst & pend_q;
    pc_valid  = ~rst & (state_q == StFetch);
    pc        = rst ? '0 : pc_q;
    step_cnt  = rst ? '0 : cnt_q;
    state     = rst ? 2'b00 : state_q;
  end

endmodule
